// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem word reads, buffers returns, feeds decode.
// Define FETCH_PERF_CNT_EN to add fetch_count/discard_count counters.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       discard_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];

  logic              run;
  logic              redir;
  logic              accept;
  logic              resp;
  logic              drop;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit;
  logic [CNT_W-1:0]  out_nx;
  logic [CNT_W-1:0]  dis_nx;
  logic [ADDR_W-1:0] redir_pc;

  assign run      = (state == RUN);
  assign redir    = run && redirect_valid;
  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign credit   = {1'b0, outstanding} + {1'b0, fifo_count};

  assign imem_req  = run && !redirect_valid && (credit < DEPTH_C);
  assign imem_addr = fetch_pc;

  assign accept = imem_req && imem_gnt;
  assign resp   = run && imem_rvalid;
  assign drop   = resp && (discard != '0);
  assign push   = resp && (discard == '0) && !redir;

  assign instr_valid = (fifo_count != '0);
  assign instr       = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign pop         = instr_valid && instr_ready && !redir;

  assign out_nx = outstanding + CNT_W'(accept) - CNT_W'(resp);

  // Stale responses still in flight after a redirect are counted off here.
  always_comb begin
    dis_nx = discard;
    if (redir)
      dis_nx = out_nx;
    else if (drop)
      dis_nx = discard - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (state == BOOT)
        state <= RUN;
      outstanding <= out_nx;
      discard     <= dis_nx;
      if (redir) begin
        fetch_pc   <= redir_pc;
        resp_pc    <= redir_pc;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push) begin
          data_q[wr_ptr] <= imem_rdata;
          pc_q[wr_ptr]   <= resp_pc;
          wr_ptr         <= wr_ptr + 1'b1;
          resp_pc        <= resp_pc + ADDR_W'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      if (push)
        fetch_count <= fetch_count + 32'd1;
      if (resp && !push)
        discard_count <= discard_count + 32'd1;
    end
  end
`endif

  a_rvalid_credit: assert property (
    @(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (default build).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rp;
    logic        g;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rv, input logic [31:0] rp,
                     input logic g, input logic v,
                     input logic [31:0] d, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_ins,
                     input logic [31:0] e_pc);
    vec_t x;
    x.rv = rv; x.rp = rp; x.g = g; x.v = v; x.d = d; x.rdy = rdy;
    x.e_req = e_req; x.e_addr = e_addr; x.e_iv = e_iv;
    x.e_ins = e_ins; x.e_pc = e_pc;
    vt.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rp,
                       input logic g, input logic v,
                       input logic [31:0] d, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = d;
    instr_ready    = rdy;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    //   rv rp            g  v  rdata         rdy  req addr          iv ins           pc
    // streaming from reset, 1-cycle responses
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_0000,1,   1, 32'h0000_0004, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_0004,1,   0, 32'h0000_0008, 1, 32'hD000_0000,32'h0);
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'hD000_0004,32'h4);
    add(0, 32'h0,        1, 1, 32'hD000_0008,1,   1, 32'h0000_000C, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_000C,1,   0, 32'h0000_0010, 1, 32'hD000_0008,32'h8);
    add(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h0000_0010, 1, 32'hD000_000C,32'hC);
    // decode back-pressure: credit stops requests, head holds
    add(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0000_0010, 1, 32'hD000_000C,32'hC);
    add(0, 32'h0,        1, 1, 32'hD000_0010,0,   0, 32'h0000_0014, 1, 32'hD000_000C,32'hC);
    add(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h0000_0014, 1, 32'hD000_000C,32'hC);
    add(0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h0000_0014, 1, 32'hD000_000C,32'hC);
    add(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0000_0014, 1, 32'hD000_0010,32'h10);
    add(0, 32'h0,        0, 1, 32'hD000_0014,1,   0, 32'h0000_0018, 1, 32'hD000_0010,32'h10);
    // grant withheld three cycles: address stays put
    add(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0000_0018, 1, 32'hD000_0014,32'h14);
    add(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0000_0018, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0000_0018, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_0018, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_001C, 0, 32'h0,        32'h0);
    // redirect to 0x1003 with two requests outstanding
    add(1, 32'h0000_1003,1, 0, 32'h0,        1,   0, 32'h0000_0020, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 1, 32'hD000_0018,1,   0, 32'h0000_1000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_001C,1,   1, 32'h0000_1000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_1000,1,   1, 32'h0000_1004, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 1, 32'hD000_1004,0,   0, 32'h0000_1008, 1, 32'hD000_1000,32'h1000);
    add(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0000_1008, 1, 32'hD000_1000,32'h1000);
    add(0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h0000_1008, 1, 32'hD000_1000,32'h1000);
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_1008, 1, 32'hD000_1004,32'h1004);
    add(0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0000_100C, 0, 32'h0,        32'h0);
    // redirect to wrap address with a stale response in the same cycle
    add(1, 32'hFFFF_FFFC,1, 1, 32'hD000_1008,1,   0, 32'h0000_1010, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_100C,1,   1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'h1234_5678,0,   1, 32'h0000_0000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0000_0004, 1, 32'h1234_5678,32'hFFFF_FFFC);
    // back-to-back redirects, last one wins
    add(1, 32'h0000_2000,1, 0, 32'h0,        0,   0, 32'h0000_0004, 1, 32'h1234_5678,32'hFFFF_FFFC);
    add(1, 32'h0000_3001,0, 0, 32'h0,        0,   0, 32'h0000_2000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        1, 1, 32'hD000_0000,1,   1, 32'h0000_3000, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 1, 32'hABCD_0003,1,   1, 32'h0000_3004, 0, 32'h0,        32'h0);
    add(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0000_3004, 1, 32'hABCD_0003,32'h3000);
    add(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0000_3004, 0, 32'h0,        32'h0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.req",   32'(imem_req),    32'h0);
    chk("rst.addr",  imem_addr,        32'h0);
    chk("rst.iv",    32'(instr_valid), 32'h0);
    chk("rst.instr", instr,            32'h0);
    chk("rst.pc",    instr_pc,         32'h0);

    // release: one BOOT cycle without a request
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("boot.req", 32'(imem_req), 32'h0);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rv, vt[i].rp, vt[i].g, vt[i].v, vt[i].d, vt[i].rdy);
      #1;
      chk($sformatf("v%0d.req", i),  32'(imem_req),    32'(vt[i].e_req));
      chk($sformatf("v%0d.addr", i), imem_addr,        vt[i].e_addr);
      chk($sformatf("v%0d.iv", i),   32'(instr_valid), 32'(vt[i].e_iv));
      if (vt[i].e_iv) begin
        chk($sformatf("v%0d.instr", i), instr,    vt[i].e_ins);
        chk($sformatf("v%0d.pc", i),    instr_pc, vt[i].e_pc);
      end
    end

    // mid-run reset with a buffered word and traffic in progress
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("mr.req0",  32'(imem_req), 32'h1);
    chk("mr.addr0", imem_addr,     32'h3004);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h55AA_55AA, 1'b0);
    #1;
    chk("mr.addr1", imem_addr, 32'h3008);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("mr.iv",    32'(instr_valid), 32'h1);
    chk("mr.instr", instr,            32'h55AA_55AA);
    chk("mr.pc",    instr_pc,         32'h3004);
    reset = 1'b0;
    #1;
    chk("mr.rst.iv",   32'(instr_valid), 32'h0);
    chk("mr.rst.req",  32'(imem_req),    32'h0);
    chk("mr.rst.addr", imem_addr,        32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("mr.boot.req", 32'(imem_req), 32'h0);
    @(negedge clk);
    #1;
    chk("mr.run.req",  32'(imem_req), 32'h1);
    chk("mr.run.addr", imem_addr,     32'h0);
    chk("mr.run.iv",   32'(instr_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h7777_0000, 1'b1);
    #1;
    chk("mr.run.addr2", imem_addr, 32'h4);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0004, 1'b1);
    #1;
    chk("mr.run.iv2",  32'(instr_valid), 32'h1);
    chk("mr.run.ins2", instr,            32'h7777_0000);
    chk("mr.run.pc2",  instr_pc,         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
